// File: rtl/whack_pkg.sv
// Shared types and width helpers for the whack-a-mole round scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of hits between successive show-window reductions.
  localparam int SPEEDUP_STEP = 4;

  // Width of a mole index; kept at least 1 so buses never collapse.
  function automatic int idx_w(input int n_moles);
    return (n_moles > 1) ? $clog2(n_moles) : 1;
  endfunction

  // Width needed to hold a count value up to and including maxval.
  function automatic int cnt_w(input int maxval);
    return (maxval > 1) ? $clog2(maxval + 1) : 1;
  endfunction

endpackage

// File: rtl/wam_tick_timer.sv
// Loadable down-counter of tick pulses; done fires on the tick that takes it to zero.
// Latency: done is combinational with the qualifying tick (same cycle).
// Backpressure: none; load wins over a coincident tick.
module wam_tick_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload has priority, otherwise step down on each tick, parking at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = tick_i & (cnt_q == W'(1));

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole game sequencer: gap, show one mole, score hit/miss, for ROUNDS rounds.
// Latency: btn/tick decisions appear on mole/score/misses/pulses one cycle later.
// Backpressure: none; start outside IDLE/DONE and btn outside SHOW are dropped. Option: MOLE_SPEEDUP_EN.
module mole_round_scheduler
  import whack_pkg::*;
#(
  parameter int N_MOLES    = 8,
  parameter int GAP_TICKS  = 2,
  parameter int SHOW_TICKS = 4,
  parameter int MIN_SHOW   = 1,
  parameter int ROUNDS     = 20,
  parameter int SCORE_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      tick,
  input  logic [idx_w(N_MOLES)-1:0] rnd,
  input  logic [N_MOLES-1:0]        btn,
  output logic                      tick_en,
  output logic [N_MOLES-1:0]        mole,
  output logic [SCORE_W-1:0]        score,
  output logic [SCORE_W-1:0]        misses,
  output logic                      hit_pulse,
  output logic                      miss_pulse,
  output logic                      busy,
  output logic                      game_over
);

  localparam int IDX_W = idx_w(N_MOLES);
  // The shared timer must hold the largest value it can ever be loaded with.
  localparam int MAX_LOAD_A = (GAP_TICKS > SHOW_TICKS) ? GAP_TICKS : SHOW_TICKS;
  localparam int MAX_LOAD   = (MAX_LOAD_A > MIN_SHOW) ? MAX_LOAD_A : MIN_SHOW;
  localparam int CNT_W      = cnt_w(MAX_LOAD);
  localparam int RND_W      = cnt_w(ROUNDS);

  state_t             state_q, state_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] misses_q, misses_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic               start_ok;
  logic               hit_now;
  logic               miss_now;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_done;
  logic [CNT_W-1:0]   window;
  logic [N_MOLES-1:0] target;

  assign target   = N_MOLES'(1) << idx_q;
  assign tick_en  = (state_q == GAP) || (state_q == SHOW);
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  // One timer serves both the gap and the show window; ticks only count while enabled.
  wam_tick_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (tick & tick_en),
    .done_o     (tmr_done)
  );

`ifdef MOLE_SPEEDUP_EN
  localparam int STEP_W = cnt_w(SPEEDUP_STEP - 1);

  logic [CNT_W-1:0]  win_q, win_d;
  logic [STEP_W-1:0] step_q, step_d;

  // Shrink the show window by one after every SPEEDUP_STEP hits, floored at MIN_SHOW.
  always_comb begin
    win_d  = win_q;
    step_d = step_q;
    if (start_ok) begin
      win_d  = CNT_W'(SHOW_TICKS);
      step_d = '0;
    end else if (hit_now) begin
      if (step_q == STEP_W'(SPEEDUP_STEP - 1)) begin
        step_d = '0;
        if (win_q > CNT_W'(MIN_SHOW)) begin
          win_d = win_q - CNT_W'(1);
        end
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  // Window and hit-step registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      step_q <= '0;
    end else begin
      win_q  <= win_d;
      step_q <= step_d;
    end
  end

  assign window = win_q;
`else
  assign window = CNT_W'(SHOW_TICKS);
`endif

  // Next-state and bookkeeping: hit beats wrong press beats timeout within SHOW.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    score_d  = score_q;
    misses_d = misses_q;
    idx_d    = idx_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    hit_now  = 1'b0;
    miss_now = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = CNT_W'(GAP_TICKS);

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d  = GAP;
          round_d  = '0;
          score_d  = '0;
          misses_d = '0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_TICKS);
        end
      end
      GAP: begin
        if (tmr_done) begin
          state_d  = SHOW;
          idx_d    = rnd;
          tmr_load = 1'b1;
          tmr_val  = window;
        end
      end
      SHOW: begin
        if (btn == target) begin
          hit_now = 1'b1;
        end else if (btn != '0) begin
          miss_now = 1'b1;
        end else if (tmr_done) begin
          miss_now = 1'b1;
        end

        if (hit_now || miss_now) begin
          hit_d    = hit_now;
          miss_d   = miss_now;
          round_d  = round_q + RND_W'(1);
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_TICKS);
          state_d  = (round_d == RND_W'(ROUNDS)) ? DONE : GAP;
          if (hit_now && (score_q != '1)) begin
            score_d = score_q + SCORE_W'(1);
          end
          if (miss_now && (misses_q != '1)) begin
            misses_d = misses_q + SCORE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      round_q  <= '0;
      score_q  <= '0;
      misses_q <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign mole       = (state_q == SHOW) ? target : '0;
  assign score      = score_q;
  assign misses     = misses_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign busy       = tick_en;
  assign game_over  = (state_q == DONE);

endmodule
